// File: rtl/mha_pkg.sv
// Shared types and width helpers for the MHA linear-projection datapath.
package mha_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/collector_bank_ram.sv
// Two-bank word store for the output collector: synchronous write, asynchronous read.
module collector_bank_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Address is {bank, idx}; depth equals 2*COL_Y when COL_Y is a power of two.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ping_pong_out_collector.sv
// Captures finished accumulator blocks into two alternating row banks and
// streams each completed row out as a valid/ready burst with last marking row end.
module ping_pong_out_collector
  import mha_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int COL_Y      = 2,
  parameter int TOTAL_ROWS = 4,
  localparam int IDX_WIDTH = clog2_min1(COL_Y),
  localparam int ROW_WIDTH = clog2_min1(TOTAL_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  full,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ROW_WIDTH-1:0]  out_row_idx,
  output logic                  overflow,
  output logic                  done
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(COL_Y - 1);
  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(TOTAL_ROWS - 1);

  bank_state_t st_q [2];
  bank_state_t st_d [2];

  logic                  wr_bank_q, wr_bank_d;
  logic [IDX_WIDTH-1:0]  wr_idx_q, wr_idx_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [IDX_WIDTH-1:0]  rd_idx_q, rd_idx_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [ROW_WIDTH-1:0]  row_idx_q, row_idx_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;

  logic                  writable;
  logic                  we;
  logic                  hs;
  logic [IDX_WIDTH-1:0]  rd_idx_inc;
  logic [IDX_WIDTH-1:0]  raddr_idx;
  logic [DATA_WIDTH-1:0] rdata;

  assign writable   = (st_q[wr_bank_q] == EMPTY) || (st_q[wr_bank_q] == FILLING);
  assign we         = in_valid & writable & ~done_q;
  assign hs         = valid_q & out_ready;
  assign rd_idx_inc = rd_idx_q + IDX_WIDTH'(1);
  // Read address looks ahead to the word registered at this edge.
  assign raddr_idx  = hs ? rd_idx_inc : '0;

  collector_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (IDX_WIDTH + 1)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wr_bank_q, wr_idx_q}),
    .wdata (in_data),
    .raddr ({rd_bank_q, raddr_idx}),
    .rdata (rdata)
  );

  always_comb begin
    st_d       = st_q;
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    rd_bank_d  = rd_bank_q;
    rd_idx_d   = rd_idx_q;
    row_d      = row_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    row_idx_d  = row_idx_q;
    overflow_d = overflow_q;
    done_d     = done_q;

    if (in_valid && !done_q) begin
      if (writable) begin
        if (wr_idx_q == LAST_IDX) begin
          st_d[wr_bank_q] = FULL;
          wr_idx_d        = '0;
          wr_bank_d       = ~wr_bank_q;
        end else begin
          st_d[wr_bank_q] = FILLING;
          wr_idx_d        = rd_idx_inc_w(wr_idx_q);
        end
      end else begin
        overflow_d = 1'b1;
      end
    end

    // Writes only touch EMPTY/FILLING banks and reads only FULL/DRAINING ones,
    // so both updates to st_d never target the same bank in one cycle.
    if (hs) begin
      if (rd_idx_q == LAST_IDX) begin
        st_d[rd_bank_q] = EMPTY;
        rd_bank_d       = ~rd_bank_q;
        rd_idx_d        = '0;
        row_d           = row_q + ROW_WIDTH'(1);
        valid_d         = 1'b0;
        if (row_q == LAST_ROW) done_d = 1'b1;
      end else begin
        rd_idx_d = rd_idx_inc;
        data_d   = rdata;
        last_d   = (rd_idx_inc == LAST_IDX);
      end
    end else if (!valid_q && !done_q && st_q[rd_bank_q] == FULL) begin
      st_d[rd_bank_q] = DRAINING;
      valid_d         = 1'b1;
      data_d          = rdata;
      last_d          = (COL_Y == 1);
      row_idx_d       = row_q;
    end
  end

  function automatic logic [IDX_WIDTH-1:0] rd_idx_inc_w(input logic [IDX_WIDTH-1:0] v);
    return v + IDX_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0]    <= EMPTY;
      st_q[1]    <= EMPTY;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
      row_q      <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      row_idx_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
      row_q      <= row_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      row_idx_q  <= row_idx_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign full        = ~writable;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_last    = last_q;
  assign out_row_idx = row_idx_q;
  assign overflow    = overflow_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ping_pong_out_collector.sv
// Randomized and directed bench for ping_pong_out_collector against a row-level reference model.
module tb_ping_pong_out_collector;

  localparam int DATA_WIDTH = 64;
  localparam int COL_Y      = 2;
  localparam int TOTAL_ROWS = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  full;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [1:0]            out_row_idx;
  logic                  overflow;
  logic                  done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ping_pong_out_collector #(
    .DATA_WIDTH (DATA_WIDTH),
    .COL_Y      (COL_Y),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .full        (full),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_row_idx (out_row_idx),
    .overflow    (overflow),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Reference model: accepted words in arrival order, words drained so far,
  // and whether a word is currently on offer.
  logic [DATA_WIDTH-1:0] acc_q [$];
  int unsigned           drained;
  bit                    offering;
  bit                    m_ovf;
  bit                    m_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_writable();
    int unsigned w;
    w = acc_q.size() / COL_Y;
    return (w < 2) || ((drained / COL_Y) >= w - 1);
  endfunction

  task automatic model_reset();
    acc_q.delete();
    drained  = 0;
    offering = 1'b0;
    m_ovf    = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [DATA_WIDTH-1:0] d, input bit r);
    bit          wr;
    bit          off;
    bit          dn;
    int unsigned rows_done;
    int unsigned rows_out;
    wr        = m_writable();
    off       = offering;
    dn        = m_done;
    rows_done = acc_q.size() / COL_Y;
    rows_out  = drained / COL_Y;
    if (v && !dn) begin
      if (wr) acc_q.push_back(d);
      else    m_ovf = 1'b1;
    end
    if (off && r) begin
      drained++;
      if (drained % COL_Y == 0) begin
        offering = 1'b0;
        if (drained / COL_Y == TOTAL_ROWS) m_done = 1'b1;
      end
    end else if (!off && !dn && rows_done > rows_out) begin
      offering = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check_eq("full", full, !m_writable());
    check_eq("overflow", overflow, m_ovf);
    check_eq("done", done, m_done);
    check_eq("out_valid", out_valid, offering);
    if (offering) begin
      check_eq("out_data", out_data, acc_q[drained]);
      check_eq("out_last", out_last, (drained % COL_Y) == COL_Y - 1);
      check_eq("out_row_idx", out_row_idx, (drained / COL_Y) % 4);
    end
  endtask

  // Called at a negedge: drive, advance the model across the next posedge, check.
  task automatic step(input bit v, input logic [DATA_WIDTH-1:0] d, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    model_edge(v, d, r);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_row_idx", out_row_idx, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Fill both banks with no downstream, then one more word overflows.
    for (int i = 0; i < 4; i++) step(1'b1, 64'h100 + 64'(i), 1'b0);
    check_eq("full_after4", full, 1);
    check_eq("ovf_after4", overflow, 0);
    step(1'b1, 64'hDEAD, 1'b0);
    check_eq("ovf_after5", overflow, 1);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    check_eq("ovf_sticky", overflow, 1);
    check_eq("drained4", drained, 4);

    // Basic row with first-word latency.
    do_reset();
    step(1'b1, 64'hA, 1'b1);
    step(1'b1, 64'hB, 1'b1);
    check_eq("lat_not_yet", out_valid, 0);
    step(1'b0, '0, 1'b1);
    check_eq("basic_w0", out_data, 64'hA);
    check_eq("basic_w0_last", out_last, 0);
    step(1'b0, '0, 1'b1);
    check_eq("basic_w1", out_data, 64'hB);
    check_eq("basic_w1_last", out_last, 1);
    step(1'b0, '0, 1'b1);

    // Back-pressure mid-row: data must hold for 5 stalled cycles.
    step(1'b1, 64'hC, 1'b0);
    step(1'b1, 64'hD, 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0);
      check_eq("bp_hold", out_data, 64'hC);
    end
    step(1'b0, '0, 1'b1);
    check_eq("bp_resume", out_data, 64'hD);
    check_eq("bp_row", out_row_idx, 1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Upstream honouring full: 8 blocks, 4 rows, then done.
    do_reset();
    begin
      int unsigned sent = 0;
      for (int i = 0; i < 60 && !m_done; i++) begin
        bit v;
        v = (sent < 8) && m_writable();
        step(v, 64'h1000 + 64'(sent), 1'b1);
        if (v) sent++;
      end
    end
    check_eq("conc_done", done, 1);
    check_eq("conc_drained", drained, 8);
    step(1'b1, 64'h9999, 1'b1);
    check_eq("post_done_ovf", overflow, 0);
    check_eq("post_done_valid", out_valid, 0);

    // Async reset mid-drain, then a fresh row restarts at row 0.
    do_reset();
    step(1'b1, 64'h51, 1'b0);
    step(1'b1, 64'h52, 1'b0);
    step(1'b0, '0, 1'b0);
    check_eq("pre_rst_valid", out_valid, 1);
    do_reset();
    step(1'b1, 64'h61, 1'b1);
    step(1'b1, 64'h62, 1'b1);
    step(1'b0, '0, 1'b1);
    check_eq("post_rst_row", out_row_idx, 0);
    check_eq("post_rst_data", out_data, 64'h61);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Random traffic with back-pressure, several runs from reset.
    for (int run = 0; run < 6; run++) begin
      do_reset();
      for (int i = 0; i < 120; i++) begin
        step(($urandom % 3) != 0, {$urandom, $urandom}, ($urandom % 4) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
